// File: rtl/ndn_pkg.sv
// Shared types and constants for the NDN router PIT/FIB stages.
// Provides widths, the PIT FSM state enum and the PIT entry record.
package ndn_pkg;
    localparam int PREFIX_W   = 64;
    localparam int LEN_W      = 6;
    localparam int DATA_BYTES = 1024;
    localparam int PIT_FACES  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_LOOKUP,
        S_INT_FWD,
        S_DATA_LOOKUP,
        S_DATA_XFER
    } pit_state_t;

    typedef struct packed {
        logic                 valid;
        logic [PREFIX_W-1:0]  prefix;
        logic [LEN_W-1:0]     len;
        logic [PIT_FACES-1:0] faces;
    } pit_entry_t;
endpackage

// File: rtl/pit_match.sv
// Parallel PIT comparator: finds the lowest matching entry and the
// lowest free entry. Ports: entries, key_prefix/key_len, use_len
// (interest compare includes len), hit/hit_idx, free/free_idx.
module pit_match
    import ndn_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  pit_entry_t [NUM_ENTRIES-1:0] entries,
    input  logic [PREFIX_W-1:0]          key_prefix,
    input  logic [LEN_W-1:0]             key_len,
    input  logic                         use_len,
    output logic                         hit,
    output logic [IDX_W-1:0]             hit_idx,
    output logic                         free,
    output logic [IDX_W-1:0]             free_idx
);
    // Scan downwards so the lowest index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entries[i].valid &&
                entries[i].prefix == key_prefix &&
                (!use_len || entries[i].len == key_len)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!entries[i].valid) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/pit_table.sv
// Pending Interest Table: records/aggregates interests, forwards new
// prefixes to the FIB, grants data queries and streams the payload.
// Ports: int_* interest in, fib_* FIB side, data_out* payload out,
// int_aggregated/int_dropped pulses, occupancy = valid entry count.
module pit_table
    import ndn_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_FACES   = PIT_FACES,
    parameter int FACE_W      = $clog2(NUM_FACES),
    localparam int OCC_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 int_valid,
    output logic                 int_ready,
    input  logic [PREFIX_W-1:0]  int_prefix,
    input  logic [LEN_W-1:0]     int_len,
    input  logic [FACE_W-1:0]    int_face,
    output logic                 fib_req,
    output logic [PREFIX_W-1:0]  fib_prefix,
    output logic [LEN_W-1:0]     fib_len,
    input  logic                 fib_data_req,
    input  logic [PREFIX_W-1:0]  fib_data_prefix,
    output logic                 fib_rejected,
    output logic                 fib_start_send,
    input  logic [7:0]           fib_data,
    output logic [7:0]           data_out,
    output logic                 data_out_valid,
    output logic                 data_out_last,
    output logic [NUM_FACES-1:0] data_out_faces,
    output logic                 int_aggregated,
    output logic                 int_dropped,
    output logic [OCC_W-1:0]     occupancy
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(DATA_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BYTES - 1);

    pit_state_t state, next;
    pit_entry_t [NUM_ENTRIES-1:0] tbl;

    logic [PREFIX_W-1:0]  ik_prefix;
    logic [LEN_W-1:0]     ik_len;
    logic [FACE_W-1:0]    ik_face;
    logic [PIT_FACES-1:0] onehot;

    logic             c_hit, c_free;
    logic [IDX_W-1:0] c_hit_idx, c_free_idx;
    logic             m_hit, m_free;
    logic [IDX_W-1:0] m_hit_idx, m_free_idx;

    logic [IDX_W-1:0] xfer_idx;
    logic [CNT_W-1:0] cnt;
    // Low during the grant cycle: the first byte arrives one cycle later.
    logic             xfer_run;

    logic [PREFIX_W-1:0] key_prefix;
    logic                use_len;

    // Only evaluated in IDLE; a pending data query owns the comparator.
    assign key_prefix = fib_data_req ? fib_data_prefix : int_prefix;
    assign use_len    = !fib_data_req;
    assign onehot     = PIT_FACES'(1) << ik_face;
    assign int_ready  = (state == S_IDLE) && !fib_data_req && !rst;

    pit_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_match (
        .entries    (tbl),
        .key_prefix (key_prefix),
        .key_len    (int_len),
        .use_len    (use_len),
        .hit        (c_hit),
        .hit_idx    (c_hit_idx),
        .free       (c_free),
        .free_idx   (c_free_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE: begin
                if (fib_data_req)   next = S_DATA_LOOKUP;
                else if (int_valid) next = S_INT_LOOKUP;
            end
            S_INT_LOOKUP: begin
                if (!m_hit && m_free) next = S_INT_FWD;
                else                  next = S_IDLE;
            end
            S_INT_FWD:     next = S_IDLE;
            S_DATA_LOOKUP: next = m_hit ? S_DATA_XFER : S_IDLE;
            S_DATA_XFER: begin
                if (xfer_run && cnt == LAST) next = S_IDLE;
            end
            default:       next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl            <= '0;
            ik_prefix      <= '0;
            ik_len         <= '0;
            ik_face        <= '0;
            m_hit          <= 1'b0;
            m_free         <= 1'b0;
            m_hit_idx      <= '0;
            m_free_idx     <= '0;
            xfer_idx       <= '0;
            cnt            <= '0;
            xfer_run       <= 1'b0;
            fib_req        <= 1'b0;
            fib_prefix     <= '0;
            fib_len        <= '0;
            fib_rejected   <= 1'b0;
            fib_start_send <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            data_out_faces <= '0;
            int_aggregated <= 1'b0;
            int_dropped    <= 1'b0;
            occupancy      <= '0;
        end else begin
            fib_req        <= 1'b0;
            fib_rejected   <= 1'b0;
            fib_start_send <= 1'b0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            int_aggregated <= 1'b0;
            int_dropped    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    m_hit      <= c_hit;
                    m_free     <= c_free;
                    m_hit_idx  <= c_hit_idx;
                    m_free_idx <= c_free_idx;
                    if (!fib_data_req && int_valid) begin
                        ik_prefix <= int_prefix;
                        ik_len    <= int_len;
                        ik_face   <= int_face;
                    end
                end
                S_INT_LOOKUP: begin
                    if (m_hit) begin
                        tbl[m_hit_idx].faces <= tbl[m_hit_idx].faces | onehot;
                        int_aggregated <= 1'b1;
                    end else if (m_free) begin
                        tbl[m_free_idx].valid  <= 1'b1;
                        tbl[m_free_idx].prefix <= ik_prefix;
                        tbl[m_free_idx].len    <= ik_len;
                        tbl[m_free_idx].faces  <= onehot;
                        occupancy <= occupancy + OCC_W'(1);
                    end else begin
                        int_dropped <= 1'b1;
                    end
                end
                S_INT_FWD: begin
                    fib_req    <= 1'b1;
                    fib_prefix <= ik_prefix;
                    fib_len    <= ik_len;
                end
                S_DATA_LOOKUP: begin
                    if (m_hit) begin
                        fib_start_send <= 1'b1;
                        data_out_faces <= tbl[m_hit_idx].faces;
                        xfer_idx       <= m_hit_idx;
                        cnt            <= '0;
                        xfer_run       <= 1'b0;
                    end else begin
                        fib_rejected <= 1'b1;
                    end
                end
                S_DATA_XFER: begin
                    if (!xfer_run) begin
                        xfer_run <= 1'b1;
                    end else begin
                        data_out       <= fib_data;
                        data_out_valid <= 1'b1;
                        data_out_last  <= (cnt == LAST);
                        cnt            <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            tbl[xfer_idx].valid <= 1'b0;
                            xfer_run <= 1'b0;
                            if (occupancy != '0)
                                occupancy <= occupancy - OCC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pit_table.sv
// Self-checking bench for pit_table against an array-based PIT model.
// Directed scenarios followed by randomized interest/data traffic.
module tb_pit_table;
    logic        clk = 1'b0;
    logic        rst;
    logic        int_valid;
    logic        int_ready;
    logic [63:0] int_prefix;
    logic [5:0]  int_len;
    logic [1:0]  int_face;
    logic        fib_req;
    logic [63:0] fib_prefix;
    logic [5:0]  fib_len;
    logic        fib_data_req;
    logic [63:0] fib_data_prefix;
    logic        fib_rejected;
    logic        fib_start_send;
    logic [7:0]  fib_data;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_last;
    logic [3:0]  data_out_faces;
    logic        int_aggregated;
    logic        int_dropped;
    logic [4:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pit_table dut (
        .clk             (clk),
        .rst             (rst),
        .int_valid       (int_valid),
        .int_ready       (int_ready),
        .int_prefix      (int_prefix),
        .int_len         (int_len),
        .int_face        (int_face),
        .fib_req         (fib_req),
        .fib_prefix      (fib_prefix),
        .fib_len         (fib_len),
        .fib_data_req    (fib_data_req),
        .fib_data_prefix (fib_data_prefix),
        .fib_rejected    (fib_rejected),
        .fib_start_send  (fib_start_send),
        .fib_data        (fib_data),
        .data_out        (data_out),
        .data_out_valid  (data_out_valid),
        .data_out_last   (data_out_last),
        .data_out_faces  (data_out_faces),
        .int_aggregated  (int_aggregated),
        .int_dropped     (int_dropped),
        .occupancy       (occupancy)
    );

    // Reference PIT: plain arrays, lowest index wins on both lookup and allocation.
    bit          mv[16];
    logic [63:0] mp[16];
    logic [5:0]  ml[16];
    logic [3:0]  mf[16];
    int          mocc;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mp[i] = '0; ml[i] = '0; mf[i] = '0;
        end
        mocc = 0;
    endfunction

    function automatic int find_int(logic [63:0] p, logic [5:0] l);
        for (int i = 0; i < 16; i++)
            if (mv[i] && mp[i] == p && ml[i] == l) return i;
        return -1;
    endfunction

    function automatic int find_data(logic [63:0] p);
        for (int i = 0; i < 16; i++)
            if (mv[i] && mp[i] == p) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < 16; i++)
            if (!mv[i]) return i;
        return -1;
    endfunction

    function automatic logic [127:0] all_outs();
        return {int_ready, fib_req, fib_prefix, fib_len, fib_rejected,
                fib_start_send, data_out, data_out_valid, data_out_last,
                data_out_faces, int_aggregated, int_dropped, occupancy};
    endfunction

    // Starts at a negedge with the DUT idle; ends at a negedge, idle again.
    task automatic do_interest(input logic [63:0] p, input logic [5:0] l,
                               input logic [1:0] f, input string tag);
        int h, fr, e_agg, e_req, e_drop;
        int agg_k, req_k, drop_k, nagg, nreq, ndrop;
        logic [63:0] rp;
        logic [5:0]  rl;
        h = find_int(p, l);
        fr = find_free();
        e_agg = 0; e_req = 0; e_drop = 0;
        agg_k = 0; req_k = 0; drop_k = 0;
        nagg = 0; nreq = 0; ndrop = 0;
        rp = '0; rl = '0;
        if (h >= 0) begin
            mf[h] = mf[h] | (4'b1 << f);
            e_agg = 2;
        end else if (fr >= 0) begin
            mv[fr] = 1; mp[fr] = p; ml[fr] = l; mf[fr] = 4'b1 << f;
            mocc++;
            e_req = 3;
        end else begin
            e_drop = 2;
        end
        int_valid = 1; int_prefix = p; int_len = l; int_face = f;
        #1;
        n_cmp++;
        if (int_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s int_ready: got %b want 1", tag, int_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) int_valid = 0;
            if (int_aggregated) begin nagg++; if (agg_k == 0) agg_k = k; end
            if (int_dropped) begin ndrop++; if (drop_k == 0) drop_k = k; end
            if (fib_req) begin
                nreq++;
                if (req_k == 0) begin req_k = k; rp = fib_prefix; rl = fib_len; end
            end
        end
        n_cmp++;
        if (agg_k != e_agg || nagg != (e_agg != 0 ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s aggregated: got cyc %0d n %0d want cyc %0d", tag, agg_k, nagg, e_agg);
        end
        n_cmp++;
        if (req_k != e_req || nreq != (e_req != 0 ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s fib_req: got cyc %0d n %0d want cyc %0d", tag, req_k, nreq, e_req);
        end
        n_cmp++;
        if (drop_k != e_drop || ndrop != (e_drop != 0 ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s dropped: got cyc %0d n %0d want cyc %0d", tag, drop_k, ndrop, e_drop);
        end
        if (e_req != 0) begin
            n_cmp++;
            if (rp !== p || rl !== l) begin
                n_bad++;
                $display("FAIL %s fib_prefix/len: got %h/%0d want %h/%0d", tag, rp, rl, p, l);
            end
        end
        n_cmp++;
        if (occupancy !== 5'(mocc)) begin
            n_bad++;
            $display("FAIL %s occupancy: got %0d want %0d", tag, occupancy, mocc);
        end
    endtask

    // Data query; payload byte i = i + seed. abort_at >= 0 asserts rst after that byte.
    task automatic do_data(input logic [63:0] p, input logic [7:0] seed,
                           input int abort_at, input bit hold_int, input string tag);
        int h, kmax, ss_k, rj_k, nss, nrj, nvalid, nlast, last_idx, bad, badf, early;
        bit aborted;
        logic [3:0] ef;
        h = find_data(p);
        ef = (h >= 0) ? mf[h] : 4'h0;
        kmax = (h < 0) ? 3 : 1028;
        ss_k = 0; rj_k = 0; nss = 0; nrj = 0; nvalid = 0; nlast = 0;
        last_idx = -1; bad = 0; badf = 0; early = 0; aborted = 0;
        fib_data_req = 1; fib_data_prefix = p;
        if (hold_int) begin
            int_valid = 1; int_prefix = 64'h77; int_len = 6'd8; int_face = 2'd0;
        end
        #1;
        n_cmp++;
        if (int_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready_during_query: got %b want 0", tag, int_ready);
        end
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 1) fib_data_req = 0;
            if (fib_start_send) begin nss++; if (ss_k == 0) ss_k = k; end
            if (fib_rejected) begin nrj++; if (rj_k == 0) rj_k = k; end
            if (data_out_valid) begin
                nvalid++;
                if (data_out !== 8'(k - 4 + int'(seed))) bad++;
                if (data_out_faces !== ef) badf++;
                if (data_out_last) begin nlast++; last_idx = k - 4; end
            end
            if (hold_int && int_ready) early++;
            fib_data = 8'(k - 3 + int'(seed));
            if (abort_at >= 0 && k - 4 == abort_at) begin
                aborted = 1;
                break;
            end
        end
        if (h < 0) begin
            n_cmp++;
            if (rj_k != 2 || nrj != 1 || nss != 0 || nvalid != 0) begin
                n_bad++;
                $display("FAIL %s reject: got rj cyc %0d n %0d ss %0d valid %0d want rj cyc 2 n 1",
                         tag, rj_k, nrj, nss, nvalid);
            end
        end else begin
            n_cmp++;
            if (ss_k != 2 || nss != 1 || nrj != 0) begin
                n_bad++;
                $display("FAIL %s start_send: got cyc %0d n %0d rj %0d want cyc 2 n 1",
                         tag, ss_k, nss, nrj);
            end
            n_cmp++;
            if (nvalid != (aborted ? abort_at + 1 : 1024) || bad != 0 || badf != 0) begin
                n_bad++;
                $display("FAIL %s stream: got %0d bytes %0d bad data %0d bad faces want %0d bytes faces %b",
                         tag, nvalid, bad, badf, aborted ? abort_at + 1 : 1024, ef);
            end
            n_cmp++;
            if (nlast != (aborted ? 0 : 1) || (!aborted && last_idx != 1023)) begin
                n_bad++;
                $display("FAIL %s last: got n %0d at %0d want n %0d at 1023",
                         tag, nlast, last_idx, aborted ? 0 : 1);
            end
            if (!aborted) begin
                mv[h] = 0;
                mocc--;
            end
        end
        if (hold_int) begin
            n_cmp++;
            if (early != 0) begin
                n_bad++;
                $display("FAIL %s ready_during_xfer: got %0d cycles want 0", tag, early);
            end
        end
        if (aborted) begin
            rst = 1;
            #1;
            n_cmp++;
            if (all_outs() !== '0) begin
                n_bad++;
                $display("FAIL %s abort_outputs: got %h want 0", tag, all_outs());
            end
            int_valid = 0;
            fib_data = '0;
            @(negedge clk);
            rst = 0;
            m_reset();
        end
        n_cmp++;
        if (occupancy !== 5'(mocc)) begin
            n_bad++;
            $display("FAIL %s occupancy: got %0d want %0d", tag, occupancy, mocc);
        end
    endtask

    task automatic test_reset();
        rst = 1; int_valid = 0; int_prefix = '0; int_len = '0; int_face = '0;
        fib_data_req = 0; fib_data_prefix = '0; fib_data = '0;
        m_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (all_outs() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if (int_ready !== 1'b1 || occupancy !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got ready %b occ %0d want 1 0", int_ready, occupancy);
        end
    endtask

    task automatic test_new_interest();
        do_interest(64'hA5, 6'd8, 2'd1, "new_interest");
    endtask

    task automatic test_aggregate();
        do_interest(64'hA5, 6'd8, 2'd2, "aggregate");
    endtask

    task automatic test_grant();
        n_cmp++;
        if (mf[find_data(64'hA5)] !== 4'b0110) begin
            n_bad++;
            $display("FAIL model_faces: got %b want 0110", mf[find_data(64'hA5)]);
        end
        do_data(64'hA5, 8'h00, -1, 0, "grant");
    endtask

    task automatic test_reject();
        do_data(64'h33, 8'h00, -1, 0, "reject");
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++)
            do_interest(i == 5 ? 64'hA5 : 64'h1000 + 64'(i), 6'd8, 2'(i), "fill");
        do_interest(64'hFFFF, 6'd8, 2'd3, "overflow");
        do_interest(64'hA5, 6'd8, 2'd2, "aggregate_full");
    endtask

    task automatic test_back_to_back();
        do_data(64'hA5, 8'($urandom), 500, 1, "b2b_abort");
        do_data(64'hA5, 8'h00, -1, 0, "post_reset_reject");
    endtask

    task automatic test_random();
        logic [63:0] pool[6];
        pool[0] = 64'hA5;
        pool[1] = 64'h33;
        pool[2] = 64'hDEAD_BEEF_0000_0001;
        pool[3] = 64'h1234_5678;
        pool[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        pool[5] = 64'h0;
        for (int n = 0; n < 30; n++) begin
            logic [63:0] p;
            p = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0)
                do_data(p, 8'($urandom), -1, 0, "rand_data");
            else
                do_interest(p, $urandom_range(0, 1) ? 6'd8 : 6'd16,
                            2'($urandom), "rand_int");
        end
    endtask

    initial begin
        test_reset();
        test_new_interest();
        test_aggregate();
        test_grant();
        test_reject();
        test_full();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pit_table.md
Name: pit_table

Overview:
- Pending Interest Table stage of the NDN router, wrapped around the FIB.
- Interest path: records each new interest, aggregates duplicate interests, and forwards only new prefixes to the FIB for longest-prefix match.
- Data path: answers the FIB's "was this requested?" query with a reject or grant, then streams the granted 1024-byte payload out, tagged with the requesting-face bitmap, and frees the entry.

Parameters:
- NUM_ENTRIES, 16, number of PIT entries.
- NUM_FACES, 4, number of router faces; width of the face bitmap.
- FACE_W, 2, width of a face index (clog2 of NUM_FACES).
- DATA_BYTES, 1024, payload length per data packet.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- int_valid  in  1  an interest is presented.
- int_ready  out  1  PIT accepts the interest this cycle.
- int_prefix  in  64  interest name prefix, zero-padded.
- int_len  in  6  interest prefix length.
- int_face  in  FACE_W  arrival face of the interest.
- fib_req  out  1  one-cycle pulse: forward the prefix to the FIB (drives FIB fib_out_bit).
- fib_prefix  out  64  forwarded prefix; held until the next forward (drives FIB pit_in_prefix).
- fib_len  out  6  forwarded length; held until the next forward (drives FIB pit_in_len).
- fib_data_req  in  1  FIB data-prefix query valid (from FIB prefix_ready).
- fib_data_prefix  in  64  prefix of the arriving data packet.
- fib_rejected  out  1  one-cycle pulse: no pending interest for the queried prefix.
- fib_start_send  out  1  one-cycle pulse: grant, FIB starts the byte stream.
- fib_data  in  8  payload byte from the FIB.
- data_out  out  8  payload byte to the output faces.
- data_out_valid  out  1  data_out is valid.
- data_out_last  out  1  marks the final payload byte.
- data_out_faces  out  NUM_FACES  destination face bitmap; stable for the whole packet.
- int_aggregated  out  1  pulse: interest merged into an existing entry.
- int_dropped  out  1  pulse: interest dropped because the table is full.
- occupancy  out  clog2(NUM_ENTRIES+1)  number of valid entries.

Behaviour:
- Reset values:
  - All entries invalid.
  - Every output is 0, including fib_prefix and fib_len.
  - occupancy is 0.
  - FSM in IDLE.
  - Reset mid-transfer aborts the transfer immediately; no data_out_last is issued.
- Entry contents: valid, prefix[63:0], len[5:0], faces[NUM_FACES-1:0].
- Lookup: fully parallel compare in one cycle; the result (hit, hit index, lowest free index) is registered.
  - Interest match: prefix and len both equal.
  - Data match: 64-bit prefix equal; len is ignored.
- FSM states: IDLE, INT_LOOKUP, INT_FWD, DATA_LOOKUP, DATA_XFER.
- IDLE:
  - fib_data_req has priority: capture fib_data_prefix, go to DATA_LOOKUP.
  - Otherwise, if int_valid: int_ready=1, capture the interest, go to INT_LOOKUP.
  - int_ready is 1 only in IDLE with fib_data_req=0.
- INT_LOOKUP, three outcomes:
  - Hit: OR the int_face bit into the entry's faces, pulse int_aggregated, go to IDLE. No FIB forward.
  - Miss with a free entry: write the entry using the lowest free index, faces=onehot(int_face), occupancy+1, go to INT_FWD.
  - Miss with the table full: pulse int_dropped, go to IDLE.
- INT_FWD: drive fib_prefix/fib_len, pulse fib_req for 1 cycle, go to IDLE. Interest latency to fib_req is 3 cycles from acceptance.
- DATA_LOOKUP:
  - Miss: pulse fib_rejected, go to IDLE.
  - Hit: pulse fib_start_send, latch the entry's faces into data_out_faces, clear the 10-bit byte counter, go to DATA_XFER.
  - The response cycle is the 2nd cycle after fib_data_req is sampled.
- DATA_XFER:
  - fib_data is sampled every cycle starting the cycle after fib_start_send.
  - data_out <= fib_data, data_out_valid=1 (registered, 1-cycle latency).
  - Counter increments per byte. data_out_last accompanies the byte with counter==DATA_BYTES-1.
  - After the last byte: entry invalid, occupancy-1, go to IDLE.
- Entry locking: the granted entry stays valid during DATA_XFER.
  - Interests are not accepted during DATA_XFER (int_ready=0), so no face can join mid-packet.
- Simultaneous fib_data_req and int_valid in IDLE: data first; the interest waits with int_ready=0.
- fib_data_req outside IDLE is ignored. The FIB issues one query at a time and waits for the response.
- Arithmetic rules:
  - occupancy never wraps: a full table drops, and an empty table never frees.
  - The byte counter wraps 1023->0 only on exit from DATA_XFER.

Decomposition:
- Package ndn_pkg holds:
  - PREFIX_W=64, LEN_W=6, DATA_BYTES=1024.
  - pit_state_t enum.
  - pit_entry_t struct {valid, prefix, len, faces}.
- One sub-module, pit_match: the combinational parallel comparator producing hit, hit_idx and free_idx. It is instantiated once, with the key muxed by state.

Test Plan:
- New interest (prefix 0xA5, len 8, face 1) -> fib_req pulses 3 cycles after acceptance with fib_prefix=0xA5, fib_len=8; occupancy=1.
- Same interest again from face 2 -> int_aggregated pulse, no fib_req; entry faces=4'b0110.
- fib_data_req with prefix 0xA5 -> fib_start_send 2 cycles later; 1024 bytes 0x00..0xFF repeating appear on data_out 1 cycle delayed with data_out_faces=0110; data_out_last on byte 1023; occupancy returns to 0.
- fib_data_req with unknown prefix 0x33 -> fib_rejected single pulse; no data_out_valid; occupancy unchanged.
- Fill 16 distinct interests, then a 17th -> int_dropped pulse, no fib_req, occupancy=16.
- fib_data_req and int_valid in the same cycle -> data query served first, int_ready=0 until IDLE. Then assert rst at byte 500 -> all outputs 0, occupancy 0, later queries for 0xA5 rejected.
